// File: rtl/dmac_rd_burst_gen.sv
// Splits a DMA channel read request into AXI4 AR bursts. Bursts are capped by
// MAX_BURST_LEN (16 for FIXED) and never cross a 4 KB boundary.
module dmac_rd_burst_gen #(
  parameter int unsigned ADDR_WD       = 32,
  parameter int unsigned DATA_WD       = 32,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_req_valid,
  input  logic [ADDR_WD-1:0] rd_req_addr,
  input  logic [1:0]         rd_req_burst,
  input  logic [ADDR_WD-1:0] rd_req_length,
  input  logic [2:0]         rd_req_size,
  output logic               rd_req_ack,
  output logic [ADDR_WD-1:0] rd_req_next_addr,
  output logic [ADDR_WD-1:0] rd_req_next_length,
  output logic               rd_req_done,
  output logic               ar_valid,
  input  logic               ar_ready,
  output logic [ADDR_WD-1:0] ar_addr,
  output logic [7:0]         ar_len,
  output logic [2:0]         ar_size,
  output logic [1:0]         ar_burst
);

  localparam int unsigned STRB_WD   = DATA_WD / 8;
  localparam logic [2:0]  SIZE_MAX  = 3'($clog2(STRB_WD));
  localparam int unsigned W1        = ADDR_WD + 1;
  localparam int unsigned FIXED_CAP = (MAX_BURST_LEN < 16) ? MAX_BURST_LEN : 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] ZERO  = 2'd3;

  logic [1:0]         state;
  logic [ADDR_WD-1:0] s_addr;
  logic [ADDR_WD-1:0] s_length;
  logic [2:0]         s_size;
  logic               s_fixed;

  logic [W1-1:0]      bb;
  logic [W1-1:0]      off;
  logic [W1-1:0]      addr_w;
  logic [W1-1:0]      len_w;
  logic [W1-1:0]      need;
  logic [W1-1:0]      to4k;
  logic [W1-1:0]      cap;
  logic [W1-1:0]      beats;
  logic [W1-1:0]      bytes;
  logic [W1-1:0]      consumed;
  logic [W1-1:0]      nlen;
  logic [ADDR_WD-1:0] naddr;

  assign ar_valid   = (state == ISSUE);
  assign rd_req_ack = ((state == ISSUE) && ar_ready) || (state == ZERO);

  always_comb begin
    bb     = W1'(1) << s_size;
    addr_w = {1'b0, s_addr};
    len_w  = {1'b0, s_length};
    off    = s_fixed ? '0 : (addr_w & (bb - W1'(1)));
    need   = (off + len_w + bb - W1'(1)) >> s_size;
    if (need > W1'(256)) need = W1'(256);
    // addr[11:0]-off is beat aligned, so this is always at least one beat
    to4k   = (W1'(4096) - W1'(s_addr[11:0]) + off) >> s_size;
    cap    = s_fixed ? W1'(FIXED_CAP) : W1'(MAX_BURST_LEN);
    beats  = (need < cap) ? need : cap;
    if (!s_fixed && (to4k < beats)) beats = to4k;
    bytes    = beats << s_size;
    consumed = bytes - off;
    nlen     = (len_w > consumed) ? (len_w - consumed) : '0;
    naddr    = s_fixed ? s_addr : ADDR_WD'(addr_w - off + bytes);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      s_addr             <= '0;
      s_length           <= '0;
      s_size             <= '0;
      s_fixed            <= 1'b0;
      ar_addr            <= '0;
      ar_len             <= '0;
      ar_size            <= '0;
      ar_burst           <= '0;
      rd_req_next_addr   <= '0;
      rd_req_next_length <= '0;
      rd_req_done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req_valid) begin
            s_addr   <= rd_req_addr;
            s_length <= rd_req_length;
            s_size   <= (rd_req_size > SIZE_MAX) ? SIZE_MAX : rd_req_size;
            s_fixed  <= (rd_req_burst == 2'd0);
            state    <= CALC;
          end
        end
        CALC: begin
          if (s_length == '0) begin
            rd_req_next_addr   <= s_addr;
            rd_req_next_length <= '0;
            rd_req_done        <= 1'b1;
            state              <= ZERO;
          end else begin
            ar_addr            <= s_addr;
            ar_len             <= 8'(beats - W1'(1));
            ar_size            <= s_size;
            ar_burst           <= s_fixed ? 2'd0 : 2'd1;
            rd_req_next_addr   <= naddr;
            rd_req_next_length <= ADDR_WD'(nlen);
            rd_req_done        <= (nlen == '0);
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
